// File: rtl/fifo_disp_pkg.sv
// rtl/fifo_disp_pkg.sv - digit states, blank code and hex glyph table for the FIFO display scanner
package fifo_disp_pkg;

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; b and d are the lowercase forms so they differ from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fifo_display_scan_seg_decode.sv
// rtl/fifo_display_scan_seg_decode.sv - combinational nibble to active-low seven-segment glyph
module seg_decode
  import fifo_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/fifo_display_scan.sv
// rtl/fifo_display_scan.sv - holds the last popped FIFO word and scans it onto a 4-digit display
// Optional fifo_full blink blanking is built with FIFO_DISPLAY_FULL_BLINK_EN.
module fifo_display_scan
  import fifo_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_strobe,
  input  logic [14:0] data_in,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        shown_valid
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic          cap_pend_q, cap_pend_d;
  logic [14:0]   hold_q, hold_d;
  logic          shown_valid_q, shown_valid_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  digit_t        digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          ref_wrap;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          blink_blank;

  always_comb begin
    cap_pend_d    = rd_strobe;
    hold_d        = hold_q;
    shown_valid_d = shown_valid_q;
    if (cap_pend_q) begin
      hold_d        = data_in;
      shown_valid_d = 1'b1;
    end
  end

  always_comb begin
    ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    digit_d   = digit_q;
    if (ref_wrap) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG2;
        DIG2:    digit_d = DIG3;
        default: digit_d = DIG0;
      endcase
    end
  end

  // an and seg both follow the next digit state so they switch on the same edge.
  always_comb begin
    nibble = 4'h0;
    an_d   = 4'b1110;
    case (digit_d)
      DIG0: begin
        nibble = hold_q[3:0];
        an_d   = 4'b1110;
      end
      DIG1: begin
        nibble = hold_q[7:4];
        an_d   = 4'b1101;
      end
      DIG2: begin
        nibble = hold_q[11:8];
        an_d   = 4'b1011;
      end
      default: begin
        nibble = {1'b0, hold_q[14:12]};
        an_d   = 4'b0111;
      end
    endcase
  end

  seg_decode u_seg_decode (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    seg_d = (!shown_valid_q || blink_blank) ? SEG_BLANK : glyph;
  end

`ifdef FIFO_DISPLAY_FULL_BLINK_EN
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          blink_wrap;
  logic          unused_inputs;

  // The blink counter free-runs; fifo_full only gates the blanking, never the phase.
  always_comb begin
    blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = blink_wrap ? ~phase_q : phase_q;
    blink_blank = fifo_full & phase_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign unused_inputs = fifo_empty;
`else
  logic unused_inputs;

  assign blink_blank   = 1'b0;
  assign unused_inputs = fifo_empty ^ fifo_full ^ (BLINK_DIV < 2);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend_q    <= 1'b0;
      hold_q        <= '0;
      shown_valid_q <= 1'b0;
      ref_cnt_q     <= '0;
      digit_q       <= DIG0;
      an_q          <= 4'b1110;
      seg_q         <= SEG_BLANK;
    end else begin
      cap_pend_q    <= cap_pend_d;
      hold_q        <= hold_d;
      shown_valid_q <= shown_valid_d;
      ref_cnt_q     <= ref_cnt_d;
      digit_q       <= digit_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign shown_valid = shown_valid_q;

endmodule
